// File: rtl/rv_ctrl_pkg.sv
// ============================================================
// rv_ctrl_pkg : shared encodings for the RV32I multi-cycle control
// Rev 1.0
// ============================================================
`default_nettype none

package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE  = 4'd0,
    CLS_LUI   = 4'd1,
    CLS_AUIPC = 4'd2,
    CLS_JAL   = 4'd3,
    CLS_JALR  = 4'd4,
    CLS_BR    = 4'd5,
    CLS_LOAD  = 4'd6,
    CLS_STORE = 4'd7,
    CLS_OPIMM = 4'd8,
    CLS_OP    = 4'd9
  } opclass_t;

  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM = 2'd1;
  localparam logic [1:0] PC_SEL_ALU = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  // ALU operand selects {alu_a_sel, alu_b_sel}; held unchanged from EXEC into WB.
  function automatic logic [1:0] alu_ab_sel(input opclass_t cls);
    logic [1:0] sel;
    sel = 2'b00;
    case (cls)
      CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_JALR: sel = 2'b01;
      CLS_AUIPC:                                sel = 2'b11;
      default:                                  sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_opclass_dec.sv
// ============================================================
// rv_opclass_dec : combinational RV32I opcode -> {opclass, illegal}
// Rev 1.0
// ============================================================
`default_nettype none

module rv_opclass_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass,
  output logic       illegal
);

  always_comb begin
    opclass = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:   opclass = CLS_LUI;
      OPC_AUIPC: opclass = CLS_AUIPC;
      OPC_JAL:   opclass = CLS_JAL;
      OPC_JALR:  opclass = CLS_JALR;
      OPC_BR:    opclass = CLS_BR;
      OPC_LOAD:  opclass = CLS_LOAD;
      OPC_STORE: opclass = CLS_STORE;
      OPC_OPIMM: opclass = CLS_OPIMM;
      OPC_OP:    opclass = CLS_OP;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
// ============================================================
// rv_multicycle_ctrl : RV32I multi-cycle control FSM with mem timeouts
// Rev 1.0
// ============================================================
`default_nettype none

module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       trap,
  output logic [2:0] state
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_t           cur_state;
  state_t           nxt_state;
  opclass_t         opclass;
  opclass_t         dec_class;
  logic             dec_illegal;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_inc;
  logic [TMO_W-1:0] tmo_nxt;
  logic             tmo_hit;
  logic             trap_flag;

  rv_opclass_dec u_dec (
    .opcode  (opcode),
    .opclass (dec_class),
    .illegal (dec_illegal)
  );

  assign tmo_inc = tmo_cnt + TMO_W'(1);
  assign tmo_hit = (tmo_inc == TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= ST_RESET;
      opclass   <= CLS_NONE;
      tmo_cnt   <= '0;
      trap_flag <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      tmo_cnt   <= tmo_nxt;
      if (cur_state == ST_DECODE) begin
        opclass <= dec_class;
      end
      if (nxt_state == ST_TRAP) begin
        trap_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state = cur_state;
    tmo_nxt   = '0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PC4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;
    retire    = 1'b0;

    case (cur_state)
      ST_RESET: nxt_state = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (imem_ack) begin
          ir_we     = 1'b1;
          nxt_state = ST_DECODE;
        end else begin
          tmo_nxt = tmo_inc;
          if (tmo_hit) nxt_state = ST_TRAP;
        end
      end

      ST_DECODE: nxt_state = dec_illegal ? ST_TRAP : ST_EXEC;

      ST_EXEC: begin
        {alu_a_sel, alu_b_sel} = alu_ab_sel(opclass);
        case (opclass)
          CLS_LOAD, CLS_STORE: nxt_state = ST_MEM;
          CLS_BR: begin
            pc_we     = 1'b1;
            pc_sel    = br_taken ? PC_SEL_IMM : PC_SEL_PC4;
            retire    = 1'b1;
            nxt_state = ST_FETCH;
          end
          CLS_JAL, CLS_JALR: begin
            rf_we     = 1'b1;
            wb_sel    = WB_SEL_PC4;
            pc_we     = 1'b1;
            pc_sel    = (opclass == CLS_JAL) ? PC_SEL_IMM : PC_SEL_ALU;
            retire    = 1'b1;
            nxt_state = ST_FETCH;
          end
          default: nxt_state = ST_WB;
        endcase
      end

      ST_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (opclass == CLS_STORE);
        alu_b_sel = 1'b1;
        if (dmem_ack) begin
          if (opclass == CLS_STORE) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            nxt_state = ST_FETCH;
          end else begin
            nxt_state = ST_WB;
          end
        end else begin
          tmo_nxt = tmo_inc;
          if (tmo_hit) nxt_state = ST_TRAP;
        end
      end

      ST_WB: begin
        {alu_a_sel, alu_b_sel} = alu_ab_sel(opclass);
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        nxt_state = ST_FETCH;
        case (opclass)
          CLS_LOAD: wb_sel = WB_SEL_MEM;
          CLS_LUI:  wb_sel = WB_SEL_IMM;
          default:  wb_sel = WB_SEL_ALU;
        endcase
      end

      ST_TRAP: nxt_state = ST_TRAP;

      default: nxt_state = ST_RESET;
    endcase
  end

  assign trap  = trap_flag;
  assign state = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
// ============================================================
// tb_rv_multicycle_ctrl : scoreboard bench for rv_multicycle_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       br_taken = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0] pc_sel, wb_sel;
  logic       alu_a_sel, alu_b_sel, rf_we, retire, trap;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          rst;
    bit          ia;
    bit          da;
    logic [6:0]  op;
    bit          br;
    logic [16:0] exp;
    string       tag;
  } stim_t;

  stim_t sb[$];

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire), .trap(trap),
    .state(state)
  );

  wire [16:0] obs = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
                     alu_a_sel, alu_b_sel, rf_we, wb_sel, retire, trap};

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Field order: st ireq dreq dwe irwe pcwe pcsel a b rfwe wbsel ret trap
  function automatic logic [16:0] ev(int st, bit ireq, bit dreq, bit dwe, bit irwe, bit pcwe,
                                     int pcs, bit a, bit b, bit rfwe, int wbs, bit ret, bit trp);
    return {3'(st), ireq, dreq, dwe, irwe, pcwe, 2'(pcs), a, b, rfwe, 2'(wbs), ret, trp};
  endfunction

  task automatic push(input string tag, input bit rst, input bit ia, input bit da,
                      input logic [6:0] op, input bit br, input logic [16:0] exp);
    stim_t s;
    s.tag = tag; s.rst = rst; s.ia = ia; s.da = da; s.op = op; s.br = br; s.exp = exp;
    sb.push_back(s);
  endtask

  localparam logic [16:0] E_IDLE   = 17'h0;
  localparam logic [16:0] E_DECODE = 17'(2) << 14;

  task automatic fetch_decode(input string tag, input logic [6:0] op);
    push({tag, "_fetch"},  1, 1, 0, 7'h0, 0, ev(1, 1,0,0,1,0, 0, 0,0,0, 0, 0,0));
    push({tag, "_decode"}, 1, 0, 0, op,   0, E_DECODE);
  endtask

  initial begin
    repeat (2) @(posedge clk);

    push("reset_state", 1, 0, 0, 7'h0, 0, E_IDLE);

    fetch_decode("addi", 7'b0010011);
    push("addi_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,0, 0, 0,1,0, 0, 0,0));
    push("addi_wb",   1, 0, 0, 7'h0, 0, ev(5, 0,0,0,0,1, 0, 0,1,1, 0, 1,0));

    fetch_decode("beq_nt", 7'b1100011);
    push("beq_nt_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,1, 0, 0,0,0, 0, 1,0));
    fetch_decode("beq_t", 7'b1100011);
    push("beq_t_exec",  1, 0, 0, 7'h0, 1, ev(3, 0,0,0,0,1, 1, 0,0,0, 0, 1,0));

    fetch_decode("lw", 7'b0000011);
    push("lw_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,0, 0, 0,1,0, 0, 0,0));
    for (int i = 0; i < 3; i++)
      push("lw_mem_wait", 1, 0, 0, 7'h0, 0, ev(4, 0,1,0,0,0, 0, 0,1,0, 0, 0,0));
    push("lw_mem_ack", 1, 0, 1, 7'h0, 0, ev(4, 0,1,0,0,0, 0, 0,1,0, 0, 0,0));
    push("lw_wb",      1, 0, 0, 7'h0, 0, ev(5, 0,0,0,0,1, 0, 0,1,1, 1, 1,0));

    fetch_decode("sw", 7'b0100011);
    push("sw_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,0, 0, 0,1,0, 0, 0,0));
    push("sw_mem",  1, 0, 1, 7'h0, 0, ev(4, 0,1,1,0,1, 0, 0,1,0, 0, 1,0));

    fetch_decode("jal", 7'b1101111);
    push("jal_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,1, 1, 0,0,1, 2, 1,0));
    fetch_decode("jalr", 7'b1100111);
    push("jalr_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,1, 2, 0,1,1, 2, 1,0));

    fetch_decode("lui", 7'b0110111);
    push("lui_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,0, 0, 0,0,0, 0, 0,0));
    push("lui_wb",   1, 0, 0, 7'h0, 0, ev(5, 0,0,0,0,1, 0, 0,0,1, 3, 1,0));
    fetch_decode("auipc", 7'b0010111);
    push("auipc_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,0, 0, 1,1,0, 0, 0,0));
    push("auipc_wb",   1, 0, 0, 7'h0, 0, ev(5, 0,0,0,0,1, 0, 1,1,1, 0, 1,0));
    fetch_decode("op", 7'b0110011);
    push("op_exec", 1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,0, 0, 0,0,0, 0, 0,0));
    push("op_wb",   1, 0, 0, 7'h0, 0, ev(5, 0,0,0,0,1, 0, 0,0,1, 0, 1,0));

    // Ack arriving on the cycle the timeout would fire still completes the fetch.
    for (int i = 0; i < 14; i++)
      push("fetch_wait", 1, 0, 0, 7'h0, 0, ev(1, 1,0,0,0,0, 0, 0,0,0, 0, 0,0));
    push("fetch_late_ack", 1, 1, 0, 7'h0, 0, ev(1, 1,0,0,1,0, 0, 0,0,0, 0, 0,0));
    push("late_decode",    1, 0, 0, 7'b0100011, 0, E_DECODE);
    push("late_exec",      1, 0, 0, 7'h0, 0, ev(3, 0,0,0,0,0, 0, 0,1,0, 0, 0,0));

    // Reset asserted mid-MEM drops the request.
    push("mem_before_rst", 0, 0, 0, 7'h0, 0, ev(4, 0,1,1,0,0, 0, 0,1,0, 0, 0,0));
    push("rst_mid_mem",    1, 0, 0, 7'h0, 0, E_IDLE);

    for (int i = 0; i < 15; i++)
      push("fetch_tmo_wait", 1, 0, 0, 7'h0, 0, ev(1, 1,0,0,0,0, 0, 0,0,0, 0, 0,0));
    for (int i = 0; i < 3; i++)
      push("trap_sticky", 1, 1, 1, 7'h0, 0, ev(6, 0,0,0,0,0, 0, 0,0,0, 0, 0,1));
    push("trap_rst", 0, 0, 0, 7'h0, 0, ev(6, 0,0,0,0,0, 0, 0,0,0, 0, 0,1));
    push("trap_cleared", 1, 0, 0, 7'h0, 0, E_IDLE);

    fetch_decode("illegal", 7'b0000000);
    for (int i = 0; i < 3; i++)
      push("illegal_trap", 1, 0, 0, 7'h0, 0, ev(6, 0,0,0,0,0, 0, 0,0,0, 0, 0,1));

    while (sb.size() > 0) begin
      stim_t s;
      s = sb.pop_front();
      @(negedge clk);
      rst_n    = s.rst;
      imem_ack = s.ia;
      dmem_ack = s.da;
      opcode   = s.op;
      br_taken = s.br;
      #1;
      check_eq(s.tag, obs, s.exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
